// File: rtl/tug_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tug_scorer
//  Purpose  : Round referee and rope-position scorer for tug-of-war; handles
//             normal rounds, speed rounds and the sticky match-over flag.
//             Optional TUG_SCORER_PENALTY_EN makes DARK/FAKE presses penalise.
//  Revision : 1.0  initial release
// ============================================================================
module tug_scorer #(
    parameter int HALF          = 5,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SPEED_TICKS   = 4,
    parameter int SHOW_TICKS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic       slowen,
    input  logic       leds_on,
    input  logic       clear,
    input  logic       fake,
    input  logic       speed_round,
    output logic [3:0] pos,
    output logic [7:0] cnt_l,
    output logic [7:0] cnt_r,
    output logic [1:0] wins_l,
    output logic [1:0] wins_r,
    output logic       winrnd,
    output logic       winspeed,
    output logic       speed_exit,
    output logic       Victory
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SPEED_CNT  = 2'd1,
        S_SPEED_SHOW = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    localparam logic [3:0] c_HALF        = 4'(HALF);
    localparam logic [3:0] c_MAX         = 4'(2 * HALF);
    localparam logic [3:0] c_SPEED_TICKS = 4'(SPEED_TICKS);
    localparam logic [3:0] c_SHOW_TICKS  = 4'(SHOW_TICKS);
    localparam logic [1:0] c_ROUNDS      = 2'(ROUNDS_TO_WIN);

    state_t     r_state, w_state_d;
    logic       r_clear_d, r_spd_d, r_locked;
    logic [3:0] r_tick;

    logic       w_play, w_pen, w_recentre, w_at_edge, w_can_move;
    logic       w_step_up, w_step_dn, w_edge_hit;
    logic [7:0] w_cnt_l_nxt, w_cnt_r_nxt;
    logic [3:0] w_tick_inc;
    logic       w_spd_term, w_show_term, w_inc_l, w_inc_r, w_victory_nxt;
    logic [1:0] w_wins_l_nxt, w_wins_r_nxt;

    always_comb begin
        w_play = leds_on & ~clear & ~fake & ~speed_round;
`ifdef TUG_SCORER_PENALTY_EN
        w_pen  = (~leds_on & ~clear) | (fake & ~clear);
`else
        w_pen  = 1'b0;
`endif
        w_recentre = r_clear_d & ~clear;
        w_at_edge  = (pos == 4'd0) || (pos == c_MAX);
        // Moves are frozen once an edge is reached, until the next recentre.
        w_can_move = (r_state == S_IDLE) & ~r_locked & ~w_at_edge & ~w_recentre;
        w_step_up  = w_can_move & ((w_play & pb_r & ~pb_l) | (w_pen & pb_l & ~pb_r));
        w_step_dn  = w_can_move & ((w_play & pb_l & ~pb_r) | (w_pen & pb_r & ~pb_l));
        w_edge_hit = (r_state != S_DONE) & ~r_locked & w_at_edge;

        w_cnt_l_nxt = (pb_l && cnt_l != 8'hFF) ? cnt_l + 8'd1 : cnt_l;
        w_cnt_r_nxt = (pb_r && cnt_r != 8'hFF) ? cnt_r + 8'd1 : cnt_r;
        w_tick_inc  = r_tick + 4'd1;
        w_spd_term  = (r_state == S_SPEED_CNT)  & slowen & (w_tick_inc == c_SPEED_TICKS);
        w_show_term = (r_state == S_SPEED_SHOW) & slowen & (w_tick_inc == c_SHOW_TICKS);

        // Speed-round verdict includes presses landing on the terminal tick.
        w_inc_l = (w_edge_hit & (pos == 4'd0)) | (w_spd_term & (w_cnt_l_nxt > w_cnt_r_nxt));
        w_inc_r = (w_edge_hit & (pos == c_MAX)) | (w_spd_term & (w_cnt_r_nxt > w_cnt_l_nxt));
        w_wins_l_nxt  = wins_l + {1'b0, w_inc_l};
        w_wins_r_nxt  = wins_r + {1'b0, w_inc_r};
        w_victory_nxt = Victory | (w_wins_l_nxt >= c_ROUNDS) | (w_wins_r_nxt >= c_ROUNDS);

        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_victory_nxt)
                    w_state_d = S_DONE;
                else if (speed_round & ~r_spd_d)
                    w_state_d = S_SPEED_CNT;
            end
            S_SPEED_CNT: begin
                if (w_spd_term)
                    w_state_d = S_SPEED_SHOW;
            end
            S_SPEED_SHOW: begin
                if (w_show_term)
                    w_state_d = w_victory_nxt ? S_DONE : S_IDLE;
            end
            S_DONE:  w_state_d = S_DONE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clear_d  <= 1'b0;
            r_spd_d    <= 1'b0;
            r_locked   <= 1'b0;
            r_tick     <= 4'd0;
            pos        <= c_HALF;
            cnt_l      <= 8'd0;
            cnt_r      <= 8'd0;
            wins_l     <= 2'd0;
            wins_r     <= 2'd0;
            winrnd     <= 1'b0;
            winspeed   <= 1'b0;
            speed_exit <= 1'b0;
            Victory    <= 1'b0;
        end else begin
            r_clear_d  <= clear;
            r_spd_d    <= speed_round;
            winrnd     <= w_edge_hit;
            winspeed   <= w_spd_term;
            speed_exit <= w_show_term;
            wins_l     <= w_wins_l_nxt;
            wins_r     <= w_wins_r_nxt;
            Victory    <= w_victory_nxt;

            if (w_recentre) begin
                pos      <= c_HALF;
                r_locked <= 1'b0;
            end else begin
                if (w_edge_hit)
                    r_locked <= 1'b1;
                if (w_step_up)
                    pos <= pos + 4'd1;
                else if (w_step_dn)
                    pos <= pos - 4'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_state_d == S_SPEED_CNT) begin
                        cnt_l  <= 8'd0;
                        cnt_r  <= 8'd0;
                        r_tick <= 4'd0;
                    end
                end
                S_SPEED_CNT: begin
                    cnt_l <= w_cnt_l_nxt;
                    cnt_r <= w_cnt_r_nxt;
                    if (w_spd_term)
                        r_tick <= 4'd0;
                    else if (slowen)
                        r_tick <= w_tick_inc;
                end
                S_SPEED_SHOW: begin
                    if (slowen)
                        r_tick <= w_tick_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tug_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tug_scorer
//  Purpose  : Directed self-checking bench for tug_scorer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tug_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pb_l = 1'b0, pb_r = 1'b0, slowen = 1'b0;
    logic       leds_on = 1'b0, clear = 1'b0, fake = 1'b0, speed_round = 1'b0;
    logic [3:0] pos;
    logic [7:0] cnt_l, cnt_r;
    logic [1:0] wins_l, wins_r;
    logic       winrnd, winspeed, speed_exit, Victory;

    int errors = 0;
    int checks = 0;

    tug_scorer #(
        .HALF(5), .ROUNDS_TO_WIN(3), .SPEED_TICKS(4), .SHOW_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r), .slowen(slowen),
        .leds_on(leds_on), .clear(clear), .fake(fake), .speed_round(speed_round),
        .pos(pos), .cnt_l(cnt_l), .cnt_r(cnt_r), .wins_l(wins_l), .wins_r(wins_r),
        .winrnd(winrnd), .winspeed(winspeed), .speed_exit(speed_exit), .Victory(Victory)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic recentre();
        clear = 1'b1; tick(1);
        clear = 1'b0; tick(1);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        check("reset_pos", pos, 5);
        check("reset_wins_l", wins_l, 0);
        check("reset_victory", Victory, 0);
        check("reset_winrnd", winrnd, 0);

        // Left player pulls rope to the left edge.
        leds_on = 1'b1; pb_l = 1'b1;
        tick(4);
        check("pos_after4", pos, 1);
        tick(1);
        pb_l = 1'b0;
        check("pos_left_edge", pos, 0);
        check("winrnd_early", winrnd, 0);
        tick(1);
        check("winrnd_pulse", winrnd, 1);
        check("wins_l_1", wins_l, 1);
        pb_l = 1'b1; tick(1); pb_l = 1'b0;
        check("winrnd_drop", winrnd, 0);
        check("pos_blocked", pos, 0);

        recentre();
        check("recentre_pos", pos, 5);

        pb_l = 1'b1; pb_r = 1'b1; tick(1); pb_l = 1'b0; pb_r = 1'b0;
        check("both_nomove", pos, 5);

        leds_on = 1'b0; pb_r = 1'b1; tick(1); pb_r = 1'b0;
`ifdef TUG_SCORER_PENALTY_EN
        check("dark_penalty", pos, 4);
`else
        check("dark_ignored", pos, 5);
`endif

        // Right player takes three rounds for the match.
        for (int r = 0; r < 3; r++) begin
            recentre();
            leds_on = 1'b1; pb_r = 1'b1;
            tick(5);
            pb_r = 1'b0;
            check("pos_right_edge", pos, 10);
            tick(1);
            check("winrnd_right", winrnd, 1);
            check("wins_r", wins_r, r + 1);
            check("victory_step", Victory, (r == 2) ? 1 : 0);
        end
        recentre();
        pb_l = 1'b1; tick(2); pb_l = 1'b0;
        check("done_pos_frozen", pos, 5);
        check("victory_sticky", Victory, 1);
        check("done_no_winrnd", winrnd, 0);

        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_victory", Victory, 0);

        // Speed round: left 7 presses, right 3.
        leds_on = 1'b0; speed_round = 1'b1; tick(1);
        pb_l = 1'b1; pb_r = 1'b1; tick(3);
        pb_r = 1'b0; tick(4);
        pb_l = 1'b0;
        slowen = 1'b1; tick(3);
        check("winspeed_early", winspeed, 0);
        tick(1);
        check("winspeed_pulse", winspeed, 1);
        check("spd_cnt_l", cnt_l, 7);
        check("spd_cnt_r", cnt_r, 3);
        check("spd_wins_l", wins_l, 1);
        check("spd_wins_r", wins_r, 0);
        pb_l = 1'b1; tick(1); pb_l = 1'b0;
        check("winspeed_drop", winspeed, 0);
        check("show_frozen", cnt_l, 7);
        check("exit_early", speed_exit, 0);
        tick(1);
        check("speed_exit", speed_exit, 1);
        speed_round = 1'b0; slowen = 1'b0; tick(1);
        check("exit_drop", speed_exit, 0);

        // Tie round.
        speed_round = 1'b1; tick(1);
        pb_l = 1'b1; pb_r = 1'b1; tick(4);
        pb_l = 1'b0; pb_r = 1'b0;
        slowen = 1'b1; tick(4);
        check("tie_winspeed", winspeed, 1);
        check("tie_cnt_l", cnt_l, 4);
        check("tie_wins_l", wins_l, 1);
        check("tie_wins_r", wins_r, 0);
        tick(2);
        speed_round = 1'b0; slowen = 1'b0; tick(1);

        // Saturation.
        speed_round = 1'b1; tick(1);
        pb_l = 1'b1; tick(300); pb_l = 1'b0;
        check("sat_cnt_l", cnt_l, 255);
        check("sat_cnt_r", cnt_r, 0);

        // Reset during a speed round with pos at 2.
        rst = 1'b1; tick(1); rst = 1'b0; speed_round = 1'b0;
        leds_on = 1'b1; pb_l = 1'b1; tick(5); pb_l = 1'b0; tick(1);
        check("pre_rst_wins_l", wins_l, 1);
        recentre();
        pb_l = 1'b1; tick(3); pb_l = 1'b0;
        check("pre_rst_pos", pos, 2);
        leds_on = 1'b0; speed_round = 1'b1; tick(1);
        pb_l = 1'b1; tick(2); pb_l = 1'b0;
        check("pre_rst_cnt_l", cnt_l, 2);
        slowen = 1'b1; tick(3);
        rst = 1'b1; tick(1);
        check("rst_pos", pos, 5);
        check("rst_cnt_l", cnt_l, 0);
        check("rst_wins_l", wins_l, 0);
        check("rst_winspeed", winspeed, 0);
        rst = 1'b0; slowen = 1'b0; tick(1);
        check("rst_winspeed_after", winspeed, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
